// File: rtl/crossbar_cfg_writer.sv
// Producer of the event crossbar select table: route writes land in a shadow
// table that is copied atomically to the active table (cfg_o) on commit.
module crossbar_cfg_writer #(
    parameter  int N_IN       = 32,
    parameter  int N_OUT      = 24,
    localparam int N_BITS_CFG = $clog2(N_IN),
    localparam int N_BITS_OUT = $clog2(N_OUT)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic [N_BITS_OUT-1:0]       wr_out_i,
    input  logic [N_BITS_CFG-1:0]       wr_in_i,
    input  logic                        commit_i,
    input  logic                        clear_i,
    output logic                        busy_o,
    output logic                        err_o,
    output logic [7:0]                  commit_cnt_o,
    input  logic [N_BITS_OUT-1:0]       rd_out_i,
    output logic [N_BITS_CFG-1:0]       rd_data_o,
    output logic [N_OUT*N_BITS_CFG-1:0] cfg_o
);

    typedef enum logic [1:0] {IDLE, CLEAR, COMMIT} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [N_BITS_CFG-1:0]   shadow [N_OUT];
    logic [N_BITS_CFG-1:0]   active [N_OUT];
    logic [N_BITS_OUT-1:0]   idx;
    logic                    err;
    logic [7:0]              commit_cnt;
    logic [N_BITS_CFG-1:0]   rd_data;
    logic                    wr_fire;
    logic                    wr_legal;
    logic                    rd_legal;

    always_comb begin
        state_next = state;
        wr_ready_o = 1'b0;
        case (state)
            IDLE: begin
                wr_ready_o = !clear_i && !commit_i;
                if (clear_i)
                    state_next = CLEAR;
                else if (commit_i)
                    state_next = COMMIT;
            end
            CLEAR: begin
                if (idx == N_BITS_OUT'(N_OUT - 1))
                    state_next = IDLE;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign wr_fire  = wr_valid_i && wr_ready_o;
    assign wr_legal = (32'(wr_out_i) < 32'(N_OUT)) && (32'(wr_in_i) < 32'(N_IN));
    assign rd_legal = 32'(rd_out_i) < 32'(N_OUT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            idx        <= '0;
            err        <= 1'b0;
            commit_cnt <= '0;
            rd_data    <= '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            state   <= state_next;
            rd_data <= rd_legal ? shadow[rd_out_i] : '0;
            case (state)
                IDLE: begin
                    if (clear_i) begin
                        idx <= '0;
                        err <= 1'b0;
                    end else if (wr_fire) begin
                        // Illegal writes still handshake; they only raise the sticky flag.
                        if (wr_legal)
                            shadow[wr_out_i] <= wr_in_i;
                        else
                            err <= 1'b1;
                    end
                end
                CLEAR: begin
                    shadow[idx] <= '0;
                    idx         <= idx + N_BITS_OUT'(1);
                end
                COMMIT: begin
                    for (int unsigned k = 0; k < N_OUT; k++)
                        active[k] <= shadow[k];
                    commit_cnt <= commit_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_o = '0;
        for (int unsigned k = 0; k < N_OUT; k++)
            cfg_o[k*N_BITS_CFG +: N_BITS_CFG] = active[k];
    end

    assign busy_o       = (state != IDLE);
    assign err_o        = err;
    assign commit_cnt_o = commit_cnt;
    assign rd_data_o    = rd_data;

endmodule

// File: tb/tb_crossbar_cfg_writer.sv
// Directed bench for crossbar_cfg_writer: a transaction-level model is checked
// against the DUT every cycle, plus hand-computed literal checks.
module tb_crossbar_cfg_writer;

    localparam int N_IN  = 32;
    localparam int N_OUT = 24;
    localparam int WC    = 5;
    localparam int WO    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [WO-1:0]     wr_out;
    logic [WC-1:0]     wr_in;
    logic              commit;
    logic              clear;
    logic              busy;
    logic              err;
    logic [7:0]        commit_cnt;
    logic [WO-1:0]     rd_out;
    logic [WC-1:0]     rd_data;
    logic [N_OUT*WC-1:0] cfg;

    int errors = 0;
    int checks = 0;
    bit armed  = 0;

    crossbar_cfg_writer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_out_i(wr_out), .wr_in_i(wr_in),
        .commit_i(commit), .clear_i(clear),
        .busy_o(busy), .err_o(err), .commit_cnt_o(commit_cnt),
        .rd_out_i(rd_out), .rd_data_o(rd_data), .cfg_o(cfg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_shadow [N_OUT];
    int m_active [N_OUT];
    int m_err, m_cnt, m_rd;
    int busy_left;   // cycles of pending background operation
    bit op_clear;    // 1: clear sweep pending, 0: commit pending

    always @(posedge clk) begin
        int rd_new;
        if (rst) begin
            foreach (m_shadow[k]) begin m_shadow[k] = 0; m_active[k] = 0; end
            m_err = 0; m_cnt = 0; m_rd = 0; busy_left = 0; op_clear = 0;
        end else begin
            rd_new = (int'(rd_out) < N_OUT) ? m_shadow[rd_out] : 0;
            if (busy_left > 0) begin
                if (op_clear) m_shadow[N_OUT - busy_left] = 0;
                else begin m_active = m_shadow; m_cnt = (m_cnt + 1) % 256; end
                busy_left--;
            end else if (clear) begin
                op_clear = 1; busy_left = N_OUT; m_err = 0;
            end else if (commit) begin
                op_clear = 0; busy_left = 1;
            end else if (wr_valid) begin
                if (int'(wr_out) < N_OUT && int'(wr_in) < N_IN) m_shadow[wr_out] = int'(wr_in);
                else m_err = 1;
            end
            m_rd = rd_new;
        end
    end

    always @(negedge clk) begin
        logic [N_OUT*WC-1:0] exp_cfg;
        if (armed) begin
            for (int k = 0; k < N_OUT; k++) exp_cfg[k*WC +: WC] = WC'(m_active[k]);
            chk("model cfg_o", 128'(cfg), 128'(exp_cfg));
            chk("model busy_o", 128'(busy), 128'(busy_left > 0));
            chk("model err_o", 128'(err), 128'(m_err));
            chk("model commit_cnt_o", 128'(commit_cnt), 128'(m_cnt));
            chk("model rd_data_o", 128'(rd_data), 128'(m_rd));
            chk("model wr_ready_o", 128'(wr_ready), 128'(busy_left == 0 && !clear && !commit));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int o, input int i);
        wr_valid = 1'b1; wr_out = WO'(o); wr_in = WC'(i);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
    endtask

    function automatic int entry(input int k);
        return int'(cfg[k*WC +: WC]);
    endfunction

    initial begin
        int n_busy;
        logic [7:0] cnt_saved;

        rst = 1'b1; wr_valid = 1'b0; wr_out = '0; wr_in = '0;
        commit = 1'b0; clear = 1'b0; rd_out = '0;
        tick(); tick();
        armed = 1;
        chk("reset cfg_o", 128'(cfg), 128'(0));
        chk("reset busy_o", 128'(busy), 128'(0));
        chk("reset err_o", 128'(err), 128'(0));
        chk("reset commit_cnt_o", 128'(commit_cnt), 128'(0));
        chk("reset wr_ready_o", 128'(wr_ready), 128'(1));
        rst = 1'b0;
        tick();

        // write out5=17 then commit with latency checks
        write(5, 17);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("commit N+1 busy", 128'(busy), 128'(1));
        chk("commit N+1 cfg[5]", 128'(entry(5)), 128'(0));
        tick();
        chk("commit N+2 busy", 128'(busy), 128'(0));
        chk("commit N+2 cfg[5]", 128'(entry(5)), 128'(17));
        chk("commit N+2 cfg_o", 128'(cfg), 128'(17) << 25);
        chk("commit count 1", 128'(commit_cnt), 128'(1));

        // atomicity
        write(0, 3);
        do_commit();
        write(0, 9);
        write(1, 4);
        rd_out = WO'(1);
        tick();
        chk("shadow readback out1", 128'(rd_data), 128'(4));
        chk("atomic cfg[0] held", 128'(entry(0)), 128'(3));
        chk("atomic cfg[1] held", 128'(entry(1)), 128'(0));
        do_commit();
        chk("atomic cfg[0] new", 128'(entry(0)), 128'(9));
        chk("atomic cfg[1] new", 128'(entry(1)), 128'(4));

        // clear sweep with ignored mid-sweep commit
        for (int k = 0; k < N_OUT; k++) write(k, k + 1);
        do_commit();
        cnt_saved = commit_cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_busy = 0;
        for (int c = 0; c < 30; c++) begin
            if (busy) begin
                n_busy++;
                chk("clear wr_ready low", 128'(wr_ready), 128'(0));
            end
            commit = (c == 5);
            tick();
        end
        commit = 1'b0;
        chk("clear busy cycles", 128'(n_busy), 128'(24));
        chk("clear commit ignored", 128'(commit_cnt), 128'(cnt_saved));
        chk("clear cfg[7] kept", 128'(entry(7)), 128'(8));
        chk("clear cfg[23] kept", 128'(entry(23)), 128'(24));
        do_commit();
        chk("post clear commit cfg_o", 128'(cfg), 128'(0));

        // illegal write and priority
        write(30, 7);
        chk("illegal err_o", 128'(err), 128'(1));
        rd_out = WO'(6);
        tick();
        chk("illegal shadow unchanged", 128'(rd_data), 128'(0));
        wr_valid = 1'b1; wr_out = WO'(3); wr_in = WC'(5);
        clear = 1'b1; commit = 1'b1;
        #1;
        chk("priority wr_ready low", 128'(wr_ready), 128'(0));
        cnt_saved = commit_cnt;
        tick();
        wr_valid = 1'b0; clear = 1'b0; commit = 1'b0;
        chk("priority clear entered", 128'(busy), 128'(1));
        chk("priority err cleared", 128'(err), 128'(0));
        repeat (25) tick();
        chk("priority no commit", 128'(commit_cnt), 128'(cnt_saved));
        chk("priority idle", 128'(busy), 128'(0));

        // reset in the middle of a clear sweep
        write(4, 9);
        write(20, 3);
        do_commit();
        chk("pre-reset cfg[20]", 128'(entry(20)), 128'(3));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-clear reset busy", 128'(busy), 128'(0));
        chk("mid-clear reset cfg_o", 128'(cfg), 128'(0));
        for (int k = 0; k < N_OUT; k++) begin
            rd_out = WO'(k);
            tick();
            chk("mid-clear reset readback", 128'(rd_data), 128'(0));
        end

        // commit counter wrap
        for (int k = 0; k < 255; k++) do_commit();
        chk("commit count 255", 128'(commit_cnt), 128'(255));
        do_commit();
        chk("commit count wrap", 128'(commit_cnt), 128'(0));

        tick();
        armed = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
